rv32_multicycle_sequencer: RTL and testbench

Multi-cycle control sequencer for the RV32 core. It replaces free-running single-cycle operation with an explicit FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK state machine. It owns the PC register, handshakes with instruction and data memory via request/ready, and gates the decode, execute and write-back enables. It also counts retired instructions and raises a sticky fault on memory timeout or misaligned branch target.

---
 rtl/rv32_multicycle_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_rv32_multicycle_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_multicycle_sequencer.sv
// rv32_multicycle_sequencer
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control sequencer for the
// RV32 core. Owns the PC, handshakes with instruction/data memory, gates the
// per-stage enables, counts retired instructions and raises a sticky fault on
// memory timeout.
// Optional macro RV_SEQ_ALIGN_CHECK_EN: when defined, a taken branch/jump to a
// target whose low two bits are non-zero faults in WRITEBACK. When undefined,
// the target is word-aligned by clearing its low two bits.
module rv32_multicycle_sequencer #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int unsigned     MEM_TIMEOUT = 255,
    parameter int unsigned     RETIRE_W    = 32
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    output logic [XLEN-1:0]     pc,
    output logic                fetch_request,
    input  logic                fetch_ready,
    input  logic [31:0]         fetch_data,
    output logic [31:0]         instruction,
    output logic                decode_enable,
    output logic                execute_enable,
    input  logic                control_instruction,
    input  logic                next_pc_valid,
    input  logic [XLEN-1:0]     next_pc,
    input  logic                mem_access,
    output logic                mem_request,
    input  logic                mem_ready,
    output logic                write_back_enable,
    output logic                fault,
    output logic [RETIRE_W-1:0] retired_count,
    output logic [2:0]          state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    // Timeout counter wide enough to hold MEM_TIMEOUT itself.
    localparam int unsigned TW       = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam bit          TO_EN    = (MEM_TIMEOUT != 0);
    localparam logic [TW:0] TO_LIM   = MEM_TIMEOUT[TW:0];
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    state_t              state_q, state_d;
    logic [XLEN-1:0]     pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic [RETIRE_W-1:0] ret_q, ret_d;
    logic                taken_q, taken_d;
    logic [XLEN-1:0]     target_q, target_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic [TW:0]         tcnt_inc;
    logic                timed_out;

    // The wait in FETCH/MEMORY expires on the cycle the incremented count
    // would reach MEM_TIMEOUT; a ready on that same cycle still takes priority.
    assign tcnt_inc  = {1'b0, tcnt_q} + {{TW{1'b0}}, 1'b1};
    assign timed_out = TO_EN && (tcnt_inc >= TO_LIM);

    // State, PC, instruction latch, retire counter and timeout register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            instr_q  <= '0;
            ret_q    <= '0;
            taken_q  <= 1'b0;
            target_q <= '0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            ret_q    <= ret_d;
            taken_q  <= taken_d;
            target_q <= target_d;
            tcnt_q   <= tcnt_d;
        end
    end

    // Next-state, datapath updates and per-state enables/requests.
    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        instr_d           = instr_q;
        ret_d             = ret_q;
        taken_d           = taken_q;
        target_d          = target_q;
        tcnt_d            = tcnt_q;
        fetch_request     = 1'b0;
        decode_enable     = 1'b0;
        execute_enable    = 1'b0;
        mem_request       = 1'b0;
        write_back_enable = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_FETCH;
                    tcnt_d  = '0;
                end
            end

            S_FETCH: begin
                fetch_request = 1'b1;
                if (fetch_ready) begin
                    instr_d = fetch_data;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                end else begin
                    tcnt_d = tcnt_inc[TW-1:0];
                end
            end

            S_DECODE: begin
                decode_enable = 1'b1;
                state_d       = S_EXECUTE;
            end

            S_EXECUTE: begin
                execute_enable = 1'b1;
                taken_d        = control_instruction & next_pc_valid;
                target_d       = next_pc;
                if (mem_access) begin
                    state_d = S_MEMORY;
                    tcnt_d  = '0;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end

            S_MEMORY: begin
                mem_request = 1'b1;
                if (mem_ready) begin
                    state_d = S_WRITEBACK;
                end else if (timed_out) begin
                    state_d = S_FAULT;
                end else begin
                    tcnt_d = tcnt_inc[TW-1:0];
                end
            end

            S_WRITEBACK: begin
                write_back_enable = 1'b1;
`ifdef RV_SEQ_ALIGN_CHECK_EN
                if (taken_q && (target_q[1:0] != 2'b00)) begin
                    state_d = S_FAULT;
                end else begin
                    pc_d    = taken_q ? target_q : (pc_q + PC_STEP);
                    ret_d   = ret_q + RETIRE_W'(1);
                    state_d = enable ? S_FETCH : S_IDLE;
                    tcnt_d  = '0;
                end
`else
                pc_d    = taken_q ? (target_q & ALIGN_MASK) : (pc_q + PC_STEP);
                ret_d   = ret_q + RETIRE_W'(1);
                state_d = enable ? S_FETCH : S_IDLE;
                tcnt_d  = '0;
`endif
            end

            S_FAULT: begin
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pc            = pc_q;
    assign instruction   = instr_q;
    assign retired_count = ret_q;
    assign fault         = (state_q == S_FAULT);
    assign state         = state_q;

endmodule

// File: tb/tb_rv32_multicycle_sequencer.sv
// Self-checking bench for rv32_multicycle_sequencer: a table of directed
// instructions, a randomized run against a transaction-level model, and
// hand-written timeout / reset / alignment sequences.
module tb_rv32_multicycle_sequencer;

    localparam int unsigned RW  = 4;
    localparam int unsigned TO  = 4;
    localparam logic [31:0] RPC = 32'h0000_0000;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                           ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_FAULT = 3'd6;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [31:0]   pc;
    logic          fetch_request;
    logic          fetch_ready;
    logic [31:0]   fetch_data;
    logic [31:0]   instruction;
    logic          decode_enable;
    logic          execute_enable;
    logic          control_instruction;
    logic          next_pc_valid;
    logic [31:0]   next_pc;
    logic          mem_access;
    logic          mem_request;
    logic          mem_ready;
    logic          write_back_enable;
    logic          fault;
    logic [RW-1:0] retired_count;
    logic [2:0]    state;

    rv32_multicycle_sequencer #(
        .XLEN(32),
        .RESET_PC(RPC),
        .MEM_TIMEOUT(TO),
        .RETIRE_W(RW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .pc(pc),
        .fetch_request(fetch_request),
        .fetch_ready(fetch_ready),
        .fetch_data(fetch_data),
        .instruction(instruction),
        .decode_enable(decode_enable),
        .execute_enable(execute_enable),
        .control_instruction(control_instruction),
        .next_pc_valid(next_pc_valid),
        .next_pc(next_pc),
        .mem_access(mem_access),
        .mem_request(mem_request),
        .mem_ready(mem_ready),
        .write_back_enable(write_back_enable),
        .fault(fault),
        .retired_count(retired_count),
        .state(state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Architectural model: PC and retire count advanced per instruction.
    logic [31:0] model_pc;
    int unsigned model_ret;

    typedef struct {
        logic [31:0] word;
        int unsigned fw;
        bit          mem;
        int unsigned mw;
        bit          ctrl;
        bit          valid;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        int unsigned exp_ret;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Which single strobe the spec assigns to each phase.
    function automatic logic [4:0] strobes_for(input logic [2:0] st);
        case (st)
            ST_FETCH:  return 5'b10000;
            ST_DECODE: return 5'b01000;
            ST_EXEC:   return 5'b00100;
            ST_MEM:    return 5'b00010;
            ST_WB:     return 5'b00001;
            default:   return 5'b00000;
        endcase
    endfunction

    task automatic cyc(input logic [2:0] st, input string nm);
        @(negedge clock);
        chk({nm, " state"}, state, st);
        chk({nm, " strobes"},
            {fetch_request, decode_enable, execute_enable, mem_request, write_back_enable},
            strobes_for(st));
        chk({nm, " fault"}, fault, st == ST_FAULT);
    endtask

    // Randomize every input whose value must not matter in the current phase.
    task automatic noise();
        enable              = 1'($urandom);
        fetch_ready         = 1'($urandom);
        fetch_data          = $urandom;
        mem_ready           = 1'($urandom);
        control_instruction = 1'($urandom);
        next_pc_valid       = 1'($urandom);
        next_pc             = $urandom;
        mem_access          = 1'($urandom);
    endtask

    task automatic front(input logic [31:0] word, input int unsigned fw, input bit ctrl,
                         input bit valid, input logic [31:0] tgt, input bit mem);
        for (int j = 0; j <= int'(fw); j++) begin
            cyc(ST_FETCH, "fetch");
            noise();
            fetch_ready = (j == int'(fw));
            if (j == int'(fw)) fetch_data = word;
        end
        cyc(ST_DECODE, "decode");
        chk("instr@decode", instruction, word);
        noise();
        cyc(ST_EXEC, "execute");
        chk("instr@execute", instruction, word);
        noise();
        control_instruction = ctrl;
        next_pc_valid       = valid;
        next_pc             = tgt;
        mem_access          = mem;
    endtask

    task automatic run_instr(input logic [31:0] word, input int unsigned fw, input bit mem,
                             input int unsigned mw, input bit ctrl, input bit valid,
                             input logic [31:0] tgt, input bit last,
                             input logic [31:0] exp_pc, input int unsigned exp_ret,
                             input bit exp_fault);
        front(word, fw, ctrl, valid, tgt, mem);
        if (mem) begin
            for (int j = 0; j <= int'(mw); j++) begin
                cyc(ST_MEM, "memory");
                chk("instr@memory", instruction, word);
                noise();
                mem_ready = (j == int'(mw));
            end
        end
        cyc(ST_WB, "writeback");
        chk("instr@writeback", instruction, word);
        noise();
        enable = !last;
        @(posedge clock);
        #1;
        chk("pc after wb", pc, exp_pc);
        chk("retired after wb", retired_count, exp_ret[RW-1:0]);
        if (exp_fault) chk("state after wb", state, ST_FAULT);
        else chk("state after wb", state, last ? ST_IDLE : ST_FETCH);
    endtask

    // Model update for one retired instruction.
    task automatic model_step(input bit ctrl, input bit valid, input logic [31:0] tgt);
        if (ctrl && valid) model_pc = tgt & 32'hFFFF_FFFC;
        else model_pc = model_pc + 32'd4;
        model_ret = (model_ret + 1) % (1 << RW);
    endtask

    // Reset asserted now; outputs must respond before any clock edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("reset state", state, ST_IDLE);
        chk("reset pc", pc, RPC);
        chk("reset retired", retired_count, 0);
        chk("reset instruction", instruction, 0);
        chk("reset fault", fault, 0);
        chk("reset strobes",
            {fetch_request, decode_enable, execute_enable, mem_request, write_back_enable}, 0);
        @(negedge clock);
        reset               = 1'b0;
        enable              = 1'b0;
        fetch_ready         = 1'b0;
        mem_ready           = 1'b0;
        control_instruction = 1'b0;
        next_pc_valid       = 1'b0;
        mem_access          = 1'b0;
        model_pc            = RPC;
        model_ret           = 0;
    endtask

    task automatic start();
        cyc(ST_IDLE, "idle");
        enable = 1'b1;
    endtask

    initial begin
        logic [31:0] w, t, epc;
        int unsigned fw, mw;
        bit          m, c, v;

        tbl[0] = '{32'h0000_0013, 0, 0, 0, 0, 0, 32'h0000_0000, 32'h0000_0004, 1};
        tbl[1] = '{32'h0010_0093, 0, 0, 0, 0, 0, 32'h0000_0000, 32'h0000_0008, 2};
        tbl[2] = '{32'h0000_2103, 0, 1, 3, 0, 0, 32'h0000_0000, 32'h0000_000C, 3};
        tbl[3] = '{32'h1000_006F, 0, 0, 0, 1, 1, 32'h0000_0100, 32'h0000_0100, 4};
        tbl[4] = '{32'h0000_0063, 1, 0, 0, 1, 0, 32'h0000_0200, 32'h0000_0104, 5};
        tbl[5] = '{32'h0000_0033, 2, 0, 0, 0, 1, 32'h0000_0300, 32'h0000_0108, 6};
        tbl[6] = '{32'h0020_A023, 3, 1, 0, 0, 0, 32'h0000_0000, 32'h0000_010C, 7};
        tbl[7] = '{32'hFFDF_F06F, 2, 0, 0, 1, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 8};
        tbl[8] = '{32'h0000_0013, 1, 0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 9};

        reset = 1'b1; enable = 1'b0; fetch_ready = 1'b0; fetch_data = '0;
        control_instruction = 1'b0; next_pc_valid = 1'b0; next_pc = '0;
        mem_access = 1'b0; mem_ready = 1'b0;
        model_pc = RPC; model_ret = 0;

        do_reset();

        // Directed table, back to back with enable held high at writeback.
        start();
        foreach (tbl[i]) begin
            run_instr(tbl[i].word, tbl[i].fw, tbl[i].mem, tbl[i].mw, tbl[i].ctrl,
                      tbl[i].valid, tbl[i].tgt, 1'b0, tbl[i].exp_pc, tbl[i].exp_ret, 1'b0);
        end
        model_pc  = 32'h0000_0000;
        model_ret = 9;

        // Randomized instructions checked against the model.
        for (int i = 0; i < 40; i++) begin
            w  = $urandom;
            fw = $urandom_range(0, TO - 1);
            m  = 1'($urandom);
            mw = $urandom_range(0, TO - 1);
            c  = 1'($urandom);
            v  = 1'($urandom);
`ifdef RV_SEQ_ALIGN_CHECK_EN
            t  = $urandom & 32'hFFFF_FFFC;
`else
            t  = $urandom;
`endif
            model_step(c, v, t);
            run_instr(w, fw, m, mw, c, v, t, i == 39, model_pc, model_ret, 1'b0);
        end

        // Enable low: sequencer parks in IDLE with PC held.
        for (int i = 0; i < 2; i++) begin
            cyc(ST_IDLE, "idle hold");
            chk("idle pc hold", pc, model_pc);
            chk("idle retired hold", retired_count, model_ret[RW-1:0]);
            noise();
            enable = (i == 1);
        end

        // Misaligned taken target.
`ifdef RV_SEQ_ALIGN_CHECK_EN
        run_instr(32'h1020_006F, 0, 0, 0, 1, 1, 32'h0000_0102, 1'b0,
                  model_pc, model_ret, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cyc(ST_FAULT, "misalign fault");
            chk("misalign pc frozen", pc, model_pc);
            noise();
        end
`else
        model_step(1'b1, 1'b1, 32'h0000_0102);
        run_instr(32'h1020_006F, 0, 0, 0, 1, 1, 32'h0000_0102, 1'b1,
                  32'h0000_0100, model_ret, 1'b0);
`endif
        do_reset();

        // Fetch timeout: FETCH for exactly TO cycles, then sticky FAULT.
        start();
        model_step(1'b0, 1'b0, 32'h0);
        run_instr(32'h0000_0013, 0, 0, 0, 0, 0, 32'h0, 1'b0, model_pc, model_ret, 1'b0);
        for (int i = 0; i < int'(TO); i++) begin
            cyc(ST_FETCH, "fetch stall");
            noise();
            fetch_ready = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            cyc(ST_FAULT, "fetch timeout");
            chk("fault pc frozen", pc, 32'h0000_0004);
            chk("fault retired frozen", retired_count, 1);
            noise();
            enable = 1'b1; fetch_ready = 1'b1; mem_ready = 1'b1;
        end
        do_reset();

        // Memory timeout.
        start();
        model_step(1'b0, 1'b0, 32'h0);
        run_instr(32'h0000_0013, 0, 0, 0, 0, 0, 32'h0, 1'b0, model_pc, model_ret, 1'b0);
        front(32'h0000_2083, 0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < int'(TO); i++) begin
            cyc(ST_MEM, "mem stall");
            noise();
            mem_ready = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            cyc(ST_FAULT, "mem timeout");
            chk("mem fault pc frozen", pc, 32'h0000_0004);
            noise();
        end
        do_reset();

        // Reset asserted mid-MEMORY clears everything immediately.
        start();
        model_step(1'b0, 1'b0, 32'h0);
        run_instr(32'h0000_0013, 0, 0, 0, 0, 0, 32'h0, 1'b0, model_pc, model_ret, 1'b0);
        model_step(1'b0, 1'b0, 32'h0);
        run_instr(32'h0000_0013, 0, 0, 0, 0, 0, 32'h0, 1'b0, model_pc, model_ret, 1'b0);
        front(32'h0000_2083, 0, 1'b0, 1'b0, 32'h0, 1'b1);
        cyc(ST_MEM, "mem before reset");
        noise();
        mem_ready = 1'b0;
        cyc(ST_MEM, "mem before reset");
        chk("retired before reset", retired_count, 2);
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
